// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Raster timing bundle between the VGA timing generator and its consumers
//   (pattern generators, output mux, and whoever drives the frame controls).
//
//   Signals
//     ena        : global enable; low freezes the raster
//     speed[1:0] : frame divider select, strobe every 2^speed frames
//     pause      : suppress divider strobes (step-control builds only)
//     step       : single-advance request, asynchronous to clk
//     x[9:0]     : horizontal pixel counter
//     y[9:0]     : vertical line counter
//     active     : visible-area qualifier
//     hsync      : active-low horizontal sync
//     vsync      : active-low vertical sync
//     next_frame : one-cycle frame advance strobe
//
//   Modports
//     master : the timing generator (drives raster outputs)
//     slave  : consumer/controller side (drives controls, reads raster)

interface vga_timing_gen_if;
   logic       ena;
   logic [1:0] speed;
   logic       pause;
   logic       step;
   logic [9:0] x;
   logic [9:0] y;
   logic       active;
   logic       hsync;
   logic       vsync;
   logic       next_frame;

   modport master (
      input  ena, speed, pause, step,
      output x, y, active, hsync, vsync, next_frame
   );

   modport slave (
      output ena, speed, pause, step,
      input  x, y, active, hsync, vsync, next_frame
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running 640x480@60 Hz raster timing generator. Produces pixel
//   coordinates, the active-video qualifier, active-low sync pulses and a
//   one-cycle next_frame strobe divided down by 2^speed frames.
//
//   Ports
//     clk   : pixel clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     vga   : vga_timing_gen_if.master (ena/speed/pause/step in,
//             x/y/active/hsync/vsync/next_frame out)
//
//   Build option
//     VGA_STEP_CTRL_EN : when defined, pause suppresses divider strobes and
//                        a synchronised rising edge on step requests one
//                        strobe at the next frame end. When undefined, pause
//                        and step are ignored and carry no flops.

module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic              clk,
   input  logic              rst_n,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] C_V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] C_H_PRE_FE   = 10'(H_ACTIVE - 1);
   localparam logic [9:0] C_V_LAST_ACT = 10'(V_ACTIVE - 1);
   localparam logic [9:0] C_HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] C_VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] r_x;
   logic [9:0] r_y;
   logic [2:0] r_div_cnt;
   logic       r_next_frame;

   logic       w_x_last;
   logic       w_y_last;
   logic       w_fe_edge;
   logic [2:0] w_div_thresh;
   logic       w_div_hit;
   logic       w_pause;
   logic       w_step_pending;

   assign w_x_last = (r_x == C_H_LAST);
   assign w_y_last = (r_y == C_V_LAST);

   // The strobe is registered but must be high while x/y sit on the frame-end
   // position (H_ACTIVE, V_ACTIVE-1), so the decision is made on the edge
   // that moves the counters there, i.e. from the preceding pixel.
   assign w_fe_edge = vga.ena && (r_x == C_H_PRE_FE) && (r_y == C_V_LAST_ACT);

   always_comb begin
      w_div_thresh = 3'd0;
      case (vga.speed)
         2'd0:    w_div_thresh = 3'd0;
         2'd1:    w_div_thresh = 3'd1;
         2'd2:    w_div_thresh = 3'd3;
         default: w_div_thresh = 3'd7;
      endcase
   end

   // >= rather than == so lowering speed mid-count fires on the next frame end
   assign w_div_hit = (r_div_cnt >= w_div_thresh);

`ifdef VGA_STEP_CTRL_EN
   logic r_step_meta;
   logic r_step_sync;
   logic r_step_prev;
   logic r_step_pending;
   logic w_step_rise;

   assign w_step_rise    = r_step_sync & ~r_step_prev;
   assign w_pause        = vga.pause;
   assign w_step_pending = r_step_pending;

   // Every frame end consumes the pending step; a fresh edge arriving on that
   // same edge survives for the following frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step_meta    <= 1'b0;
         r_step_sync    <= 1'b0;
         r_step_prev    <= 1'b0;
         r_step_pending <= 1'b0;
      end else if (vga.ena) begin
         r_step_meta    <= vga.step;
         r_step_sync    <= r_step_meta;
         r_step_prev    <= r_step_sync;
         r_step_pending <= (r_step_pending & ~w_fe_edge) | w_step_rise;
      end
   end
`else
   logic w_unused_step_ctrl;

   assign w_unused_step_ctrl = vga.pause ^ vga.step;
   assign w_pause            = 1'b0;
   assign w_step_pending     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x          <= 10'd0;
         r_y          <= 10'd0;
         r_div_cnt    <= 3'd0;
         r_next_frame <= 1'b0;
      end else if (vga.ena) begin
         if (w_x_last) begin
            r_x <= 10'd0;
            r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
         end else begin
            r_x <= r_x + 10'd1;
         end

         r_next_frame <= 1'b0;
         if (w_fe_edge) begin
            if (w_pause) begin
               r_next_frame <= w_step_pending;
            end else if (w_div_hit) begin
               r_next_frame <= 1'b1;
               r_div_cnt    <= 3'd0;
            end else begin
               r_div_cnt    <= r_div_cnt + 3'd1;
            end
         end
      end else begin
         r_next_frame <= 1'b0;
      end
   end

   assign vga.x          = r_x;
   assign vga.y          = r_y;
   assign vga.active     = (r_x < C_H_ACT) && (r_y < C_V_ACT);
   assign vga.hsync      = ~((r_x >= C_HS_START) && (r_x < C_HS_END));
   assign vga.vsync      = ~((r_y >= C_VS_START) && (r_y < C_VS_END));
   assign vga.next_frame = r_next_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Two instances run side by side on the same
// controls: one at the full 640x480 timing (line-level behaviour) and one
// with a shrunken raster (25 x 17, frame end after 241 clocks) so that
// multi-frame divider and step behaviour fits in a short run.

module tb_vga_timing_gen;

   // small raster parameters
   localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
   localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       active;
      logic       hsync;
      logic       vsync;
      logic       nf;
   } exp_t;

   typedef struct packed {
      int x;
      int y;
      int div;
      bit nf;
      bit pend;
   } mstate_t;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [1:0] speed;
   logic       pause;
   logic       step;

   int errors = 0;
   int checks = 0;
   int n_cyc  = 0;
   int pulses[$];

   exp_t q_d[$];
   exp_t q_s[$];

   mstate_t m_d;
   mstate_t m_s;
   bit      ms_meta, ms_sync, ms_prev;

   vga_timing_gen_if u_if_d ();
   vga_timing_gen_if u_if_s ();

   assign u_if_d.ena   = ena;
   assign u_if_d.speed = speed;
   assign u_if_d.pause = pause;
   assign u_if_d.step  = step;
   assign u_if_s.ena   = ena;
   assign u_if_s.speed = speed;
   assign u_if_s.pause = pause;
   assign u_if_s.step  = step;

   vga_timing_gen u_dut_d (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (u_if_d.master)
   );

   vga_timing_gen #(
      .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
      .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP)
   ) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (u_if_s.master)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic mstate_t m_step(input mstate_t s, input int ha, input int hfp,
                                      input int hs, input int hbp, input int va,
                                      input int vfp, input int vs, input int vbp,
                                      input bit rise);
      mstate_t n;
      int      ht;
      int      vt;
      bit      fe;
      bit      pz;
      n  = s;
      ht = ha + hfp + hs + hbp;
      vt = va + vfp + vs + vbp;
      if (!ena) begin
         n.nf = 1'b0;
         return n;
      end
      fe   = (s.x == ha - 1) && (s.y == va - 1);
      n.nf = 1'b0;
      if (s.x == ht - 1) begin
         n.x = 0;
         n.y = (s.y == vt - 1) ? 0 : s.y + 1;
      end else begin
         n.x = s.x + 1;
      end
`ifdef VGA_STEP_CTRL_EN
      pz     = pause;
      n.pend = (s.pend && !fe) || rise;
`else
      pz     = 1'b0;
      n.pend = 1'b0;
`endif
      if (fe) begin
         if (pz) n.nf = s.pend;
         else if (s.div >= (1 << speed) - 1) begin
            n.nf  = 1'b1;
            n.div = 0;
         end else begin
            n.div = s.div + 1;
         end
      end
      return n;
   endfunction

   function automatic exp_t m_out(input mstate_t s, input int ha, input int hfp,
                                  input int hs, input int va, input int vfp,
                                  input int vs);
      exp_t e;
      e.x      = 10'(s.x);
      e.y      = 10'(s.y);
      e.active = (s.x < ha) && (s.y < va);
      e.hsync  = !((s.x >= ha + hfp) && (s.x < ha + hfp + hs));
      e.vsync  = !((s.y >= va + vfp) && (s.y < va + vfp + vs));
      e.nf     = s.nf;
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_d     <= '0;
         m_s     <= '0;
         ms_meta <= 1'b0;
         ms_sync <= 1'b0;
         ms_prev <= 1'b0;
         q_d.delete();
         q_s.delete();
      end else begin
         q_d.push_back(m_out(m_step(m_d, 640, 16, 96, 48, 480, 10, 2, 33, ms_sync & ~ms_prev),
                             640, 16, 96, 480, 10, 2));
         q_s.push_back(m_out(m_step(m_s, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                                    ms_sync & ~ms_prev), S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS));
         m_d <= m_step(m_d, 640, 16, 96, 48, 480, 10, 2, 33, ms_sync & ~ms_prev);
         m_s <= m_step(m_s, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                       ms_sync & ~ms_prev);
         if (ena) begin
            ms_meta <= step;
            ms_sync <= ms_meta;
            ms_prev <= ms_sync;
         end
      end
   end

   // scoreboard: pop one expected entry per clock and compare on the far edge
   always @(negedge clk) begin
      exp_t e;
      exp_t o;
      if (q_d.size() > 0) begin
         e = q_d.pop_front();
         o = {u_if_d.x, u_if_d.y, u_if_d.active, u_if_d.hsync, u_if_d.vsync, u_if_d.next_frame};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL sb_full t=%0t got x=%0d y=%0d a=%b h=%b v=%b nf=%b exp x=%0d y=%0d a=%b h=%b v=%b nf=%b",
                     $time, o.x, o.y, o.active, o.hsync, o.vsync, o.nf,
                     e.x, e.y, e.active, e.hsync, e.vsync, e.nf);
         end
      end
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         o = {u_if_s.x, u_if_s.y, u_if_s.active, u_if_s.hsync, u_if_s.vsync, u_if_s.next_frame};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL sb_small t=%0t got x=%0d y=%0d a=%b h=%b v=%b nf=%b exp x=%0d y=%0d a=%b h=%b v=%b nf=%b",
                     $time, o.x, o.y, o.active, o.hsync, o.vsync, o.nf,
                     e.x, e.y, e.active, e.hsync, e.vsync, e.nf);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cyc = 0;
      pulses.delete();
   endtask

   task automatic collect_until(input int upto);
      while (n_cyc < upto) begin
         @(negedge clk);
         n_cyc++;
         if (u_if_s.next_frame) pulses.push_back(n_cyc);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      ena   = 1'b1;
      speed = 2'd0;
      pause = 1'b0;
      step  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({u_if_d.x, u_if_d.y} !== 20'd0) begin
         errors++;
         $display("FAIL reset_xy got x=%0d y=%0d exp 0 0", u_if_d.x, u_if_d.y);
      end
      checks++;
      if ({u_if_d.active, u_if_d.hsync, u_if_d.vsync, u_if_d.next_frame} !== 4'b1110) begin
         errors++;
         $display("FAIL reset_outs got a/h/v/nf=%b%b%b%b exp 1110",
                  u_if_d.active, u_if_d.hsync, u_if_d.vsync, u_if_d.next_frame);
      end
      rst_n = 1'b1;
      n_cyc = 0;
      @(negedge clk);
      n_cyc++;
      checks++;
      if (u_if_d.x !== 10'd1) begin
         errors++;
         $display("FAIL first_edge got x=%0d exp 1", u_if_d.x);
      end
   endtask

   task automatic test_hsync_line();
      int first = -1;
      int last  = -1;
      while (n_cyc < 800) begin
         @(negedge clk);
         n_cyc++;
         if (!u_if_d.hsync) begin
            if (first < 0) first = u_if_d.x;
            last = u_if_d.x;
         end
         if (u_if_d.x == 10'd640 && u_if_d.y == 10'd0) begin
            checks++;
            if (u_if_d.active !== 1'b0) begin
               errors++;
               $display("FAIL active_640_0 got %b exp 0", u_if_d.active);
            end
         end
      end
      checks++;
      if (first != 656 || last != 751) begin
         errors++;
         $display("FAIL hsync_range got %0d..%0d exp 656..751", first, last);
      end
      checks++;
      if (u_if_d.x !== 10'd0 || u_if_d.y !== 10'd1) begin
         errors++;
         $display("FAIL line_wrap got x=%0d y=%0d exp 0 1", u_if_d.x, u_if_d.y);
      end
   endtask

   task automatic test_ena_hold();
      int guard = 0;
      int nf_seen = 0;
      while (!(u_if_d.x == 10'd100 && u_if_d.y == 10'd10) && guard < 9000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 9000) begin
         errors++;
         $display("FAIL reach_100_10 got timeout exp position reached");
      end
      ena = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (u_if_d.next_frame || u_if_s.next_frame) nf_seen++;
      end
      checks++;
      if (u_if_d.x !== 10'd100 || u_if_d.y !== 10'd10 || nf_seen != 0) begin
         errors++;
         $display("FAIL ena_hold got x=%0d y=%0d strobes=%0d exp 100 10 0",
                  u_if_d.x, u_if_d.y, nf_seen);
      end
      ena = 1'b1;
      @(negedge clk);
      checks++;
      if (u_if_d.x !== 10'd101 || u_if_d.y !== 10'd10) begin
         errors++;
         $display("FAIL ena_resume got x=%0d y=%0d exp 101 10", u_if_d.x, u_if_d.y);
      end
   endtask

   task automatic test_speed0();
      int exp_p[$] = '{241, 666, 1091};
      int vfirst = -1;
      int vlast  = -1;
      speed = 2'd0;
      pause = 1'b0;
      do_reset();
      while (n_cyc < 1100) begin
         @(negedge clk);
         n_cyc++;
         if (u_if_s.next_frame) pulses.push_back(n_cyc);
         if (n_cyc < 425 && !u_if_s.vsync) begin
            if (vfirst < 0) vfirst = u_if_s.y;
            vlast = u_if_s.y;
         end
         if (n_cyc == 425) begin
            checks++;
            if (u_if_s.x !== 10'd0 || u_if_s.y !== 10'd0) begin
               errors++;
               $display("FAIL frame_wrap got x=%0d y=%0d exp 0 0", u_if_s.x, u_if_s.y);
            end
         end
      end
      checks++;
      if (vfirst != 12 || vlast != 13) begin
         errors++;
         $display("FAIL vsync_range got %0d..%0d exp 12..13", vfirst, vlast);
      end
      checks++;
      if (pulses.size() != exp_p.size()) begin
         errors++;
         $display("FAIL speed0_count got %0d exp %0d", pulses.size(), exp_p.size());
      end
      for (int i = 0; i < pulses.size() && i < exp_p.size(); i++) begin
         checks++;
         if (pulses[i] != exp_p[i]) begin
            errors++;
            $display("FAIL speed0_pulse%0d got %0d exp %0d", i, pulses[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_speed2();
      int exp_p[$] = '{1516, 3216};
      speed = 2'd2;
      do_reset();
      collect_until(3300);
      checks++;
      if (pulses.size() != exp_p.size()) begin
         errors++;
         $display("FAIL speed2_count got %0d exp %0d", pulses.size(), exp_p.size());
      end
      for (int i = 0; i < pulses.size() && i < exp_p.size(); i++) begin
         checks++;
         if (pulses[i] != exp_p[i]) begin
            errors++;
            $display("FAIL speed2_pulse%0d got %0d exp %0d", i, pulses[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_speed_switch();
      speed = 2'd3;
      do_reset();
      collect_until(700);
      speed = 2'd0;
      collect_until(1100);
      checks++;
      if (pulses.size() != 1 || (pulses.size() == 1 && pulses[0] != 1091)) begin
         errors++;
         $display("FAIL speed_switch got count=%0d first=%0d exp count=1 at 1091",
                  pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
      end
   endtask

   task automatic test_step_ctrl();
`ifdef VGA_STEP_CTRL_EN
      int exp_p[$] = '{241, 1091, 1516};
`else
      int exp_p[$] = '{241, 666, 1091, 1516, 1941};
`endif
      speed = 2'd0;
      pause = 1'b1;
      do_reset();
      collect_until(20);   step  = 1'b1;
      collect_until(30);   step  = 1'b0;
      collect_until(50);   step  = 1'b1;
      collect_until(60);   step  = 1'b0;
      collect_until(700);  pause = 1'b0;
      collect_until(1150); step  = 1'b1;
      collect_until(1160); step  = 1'b0;
      collect_until(1600); pause = 1'b1;
      collect_until(2000); pause = 1'b0;
      checks++;
      if (pulses.size() != exp_p.size()) begin
         errors++;
         $display("FAIL step_count got %0d exp %0d", pulses.size(), exp_p.size());
      end
      for (int i = 0; i < pulses.size() && i < exp_p.size(); i++) begin
         checks++;
         if (pulses[i] != exp_p[i]) begin
            errors++;
            $display("FAIL step_pulse%0d got %0d exp %0d", i, pulses[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      speed = 2'd0;
      pause = 1'b0;
      do_reset();
      collect_until(241);
      checks++;
      if (u_if_s.next_frame !== 1'b1 || u_if_s.x !== 10'd16 || u_if_s.y !== 10'd9) begin
         errors++;
         $display("FAIL strobe_before_rst got nf=%b x=%0d y=%0d exp 1 16 9",
                  u_if_s.next_frame, u_if_s.x, u_if_s.y);
      end
      #5;
      rst_n = 1'b0;
      #1;
      checks++;
      if (u_if_s.next_frame !== 1'b0 || u_if_s.x !== 10'd0 || u_if_s.y !== 10'd0 ||
          u_if_d.x !== 10'd0 || u_if_d.y !== 10'd0) begin
         errors++;
         $display("FAIL async_reset got nf=%b xs=%0d ys=%0d xd=%0d yd=%0d exp 0 0 0 0 0",
                  u_if_s.next_frame, u_if_s.x, u_if_s.y, u_if_d.x, u_if_d.y);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_hsync_line();
      test_ena_hold();
      test_speed0();
      test_speed2();
      test_speed_switch();
      test_step_ctrl();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
